// File: rtl/enc_final_ark_pkg.sv
// Shared AES output-tail definitions: block width, state byte-order helpers and the
// default ciphertext FIFO entry layout.
package enc_final_ark_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_BYTE_W = 8;
    localparam int AES_NROW   = 4;
    localparam int AES_NCOL   = 4;
    localparam int ENC_TAG_W  = 4;

    // Column-major state: s00 occupies [127:120], s10 [119:112], ... s33 [7:0].
    typedef struct packed {
        logic [AES_BLK_W-1:0] data;
        logic [ENC_TAG_W-1:0] tag;
    } enc_entry_t;

    // LSB position of state byte s(row,col) within the 128-bit block.
    function automatic int aes_byte_lsb(input int row, input int col);
        return AES_BLK_W - AES_BYTE_W * (AES_NROW * col + row + 1);
    endfunction

endpackage

// File: rtl/enc_out_fifo.sv
// Generic DEPTH x W synchronous circular-buffer FIFO with push, pop, flush and
// occupancy count; storage is zeroed on reset so the read port reads 0 until written.
module enc_out_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_push_s = push & (count_r != CNT_FULL);
    assign do_pop_s  = pop  & (count_r != {(AW+1){1'b0}});

    // Pointer and occupancy bookkeeping; flush discards any concurrent push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; only written on an accepted push, so idle-cycle X never lands here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/enc_final_ark.sv
// AES encryption output tail: final AddRoundKey (state ^ round key 10) feeding a small
// ciphertext FIFO with valid/ready handshakes and a delivered-block counter.
module enc_final_ark
    import enc_final_ark_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = ENC_TAG_W,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AES_BLK_W-1:0]  in_state,
    input  logic [AES_BLK_W-1:0]  in_key,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AES_BLK_W-1:0]  out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic [CNT_W-1:0]      blk_cnt
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] BLK_ONE = CNT_W'(1);

    // Same layout as the package entry, widened to this instance's tag width.
    typedef struct packed {
        logic [AES_BLK_W-1:0] data;
        logic [TAG_W-1:0]     tag;
    } entry_t;

    entry_t           wr_entry_s;
    entry_t           rd_entry_s;
    logic [AW:0]      count_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] blk_cnt_r;

    // Ready depends only on registered occupancy plus the reset/flush controls.
    assign in_ready  = (count_s != CNT_FULL) & rst_n & ~clr;
    assign out_valid = (count_s != {(AW+1){1'b0}}) & rst_n;
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    assign wr_entry_s.data = in_state ^ in_key;
    assign wr_entry_s.tag  = in_tag;

    enc_out_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clr),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wr_entry_s),
        .rdata (rd_entry_s),
        .count (count_s)
    );

    // Delivered-block counter; a pop coinciding with a flush is not a delivery.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_cnt_r <= '0;
        end else if (clr) begin
            blk_cnt_r <= blk_cnt_r;
        end else if (pop_s) begin
            blk_cnt_r <= blk_cnt_r + BLK_ONE;
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end

    assign out_data = rd_entry_s.data;
    assign out_tag  = rd_entry_s.tag;
    assign blk_cnt  = blk_cnt_r;

endmodule

// File: doc/enc_final_ark.md
Name: enc_final_ark

Overview:
- Output tail of the AES encryption datapath. Sits directly downstream of the final round, which performs SubBytes and ShiftRows with no MixColumns.
- Takes that round's 128-bit state plus round key 10, performs the final AddRoundKey, and buffers the ciphertext in a small FIFO.
- The FIFO decouples the combinational round logic from a back-pressuring consumer through a valid/ready handshake.
- Also keeps a count of delivered blocks.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the sideband tag carried with each block.
- CNT_W, 32, width of the delivered-block counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- clr  in  1  synchronous flush: empties the FIFO, counter untouched.
- in_valid  in  1  in_state/in_key/in_tag valid this cycle.
- in_ready  out  1  block can accept this cycle.
- in_state  in  128  final-round output (SubBytes+ShiftRows done); [127:120]=s00, [119:112]=s10, ... [7:0]=s33, column-major.
- in_key  in  128  round key 10, same byte order, sampled with in_state.
- in_tag  in  TAG_W  opaque sideband, returned unchanged with the block.
- out_valid  out  1  out_data/out_tag hold a ciphertext block.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  128  ciphertext, same byte order.
- out_tag  out  TAG_W  tag of the block on out_data.
- blk_cnt  out  CNT_W  number of output handshakes since reset.

Behaviour:
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH) & rst_n & ~clr. It is combinational from registered state only; no combinational path from out_ready to in_ready.
- On push, the entry written is {in_state ^ in_key, in_tag}. XOR is bitwise; no other arithmetic.
- FIFO is a circular buffer:
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- Push and pop in the same cycle:
  - count unchanged, both pointers advance.
  - Legal whenever 0 < count < DEPTH.
  - Push is impossible when full; pop is impossible when empty.
- Latency: a block pushed in cycle N is visible on out_valid/out_data in cycle N+1. No same-cycle fall-through.
- out_valid = (count != 0). out_data/out_tag = entry at rd_ptr.
- out_data/out_tag must hold stable while out_valid=1 and out_ready=0.
- Throughput: one block per cycle sustained when out_ready=1 continuously.
- blk_cnt increments by 1 on each pop and wraps from 2^CNT_W-1 to 0 with no flag.
- Reset (rst_n=0 at a clock edge):
  - pointers, count and blk_cnt go to 0.
  - out_valid=0, in_ready=0 while rst_n is low.
  - Storage contents are don't-care, but out_data and out_tag must read 0 after reset until the first push.
  - A push or pop presented in the reset cycle is ignored.
- clr=1 at a clock edge:
  - pointers and count go to 0; any simultaneous push or pop is discarded.
  - blk_cnt is not incremented for a pop presented that cycle.
  - in_ready=0 during the clr cycle.
- rst_n has priority over clr.
- Inputs are ignored while in_valid=0, and X on in_state/in_key must not propagate into state.

Decomposition:
- Shared package holds:
  - AES_BLK_W=128.
  - Byte-order helper constants, matching the round modules.
  - The entry type {data[127:0], tag}.
- One sub-module: enc_out_fifo, a generic DEPTH x W synchronous FIFO with push/pop/flush and count. The XOR and blk_cnt stay in the top.
- Upstream instantiation: the final-round module drives in_state directly, and the key-schedule output drives in_key.

Test Plan:
- FIPS-197 App. B, DEPTH=2:
  - Stimulus: in_state=e9317db5cb322c723d2e895faf090794, in_key=d014f9a8c9ee2589e13f0cc8b6630ca6, tag=3, out_ready=1.
  - Required: next cycle out_valid=1, out_data=3925841d02dc09fbdc118597196a0b32, out_tag=3; blk_cnt=1 the cycle after.
- Back-pressure:
  - Stimulus: out_ready=0, push 3 blocks on consecutive cycles.
  - Required: in_ready=0 after 2nd push; 3rd block held upstream. out_data stays block 1 unchanged. Raise out_ready: blocks 1, 2, 3 delivered in order, one per cycle; blk_cnt=3.
- Streaming:
  - Stimulus: 100 random blocks, in_valid=1 and out_ready=1 every cycle, in_key=0.
  - Required: out_data equals in_state delayed 1 cycle, with no bubble after the first; blk_cnt=100.
- Simultaneous push/pop at count=1:
  - Required: count stays 1, order preserved.
- Reset and clr:
  - Stimulus: with 2 entries queued, assert clr for 1 cycle.
  - Required: out_valid=0 next cycle, blk_cnt unchanged.
  - Stimulus: repeat with rst_n=0.
  - Required: out_valid=0, out_data=0, blk_cnt=0, in_ready=0 during reset.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 pops.
  - Required: blk_cnt reads 1.
